osd_mixer_multi: RTL and testbench

//  Multi-window on-screen-display mixer for the pixel-clock video path, between the
//  CPU video source and hdmi_interface. Overlays up to C_windows rectangular OSD

---
 rtl/osd_pkg.sv | 42 ++++
 rtl/osd_window_cmp.sv | 93 +++++++++
 rtl/osd_mixer_multi.sv | 194 +++++++++++++++++++
 tb/tb_osd_mixer_multi.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/osd_pkg.sv
// Shared constants and the pixel mixing function for the multi-window OSD mixer.
// Mode codes, config field codes and the colour-key value live here.
package osd_pkg;

  typedef enum logic [1:0] {
    OSD_OFF    = 2'd0,
    OSD_OPAQUE = 2'd1,
    OSD_KEY    = 2'd2,
    OSD_BLEND  = 2'd3
  } osd_mode_e;

  localparam logic [2:0] OSD_F_XS   = 3'd0;
  localparam logic [2:0] OSD_F_XE   = 3'd1;
  localparam logic [2:0] OSD_F_YS   = 3'd2;
  localparam logic [2:0] OSD_F_YE   = 3'd3;
  localparam logic [2:0] OSD_F_MODE = 3'd4;

  localparam logic [23:0] OSD_KEY_COLOUR = 24'h000000;

  // Blend keeps the carry in a 9-bit sum so 8'hFE + 8'h03 does not wrap.
  function automatic logic [23:0] osd_mix(input osd_mode_e mode,
                                          input logic [23:0] video,
                                          input logic [23:0] osd);
    logic [23:0] res;
    logic [8:0]  sum;
    res = video;
    sum = '0;
    case (mode)
      OSD_OPAQUE: res = osd;
      OSD_KEY:    res = (osd == OSD_KEY_COLOUR) ? video : osd;
      OSD_BLEND: begin
        for (int c = 0; c < 3; c++) begin
          sum = {1'b0, video[8*c +: 8]} + {1'b0, osd[8*c +: 8]};
          res[8*c +: 8] = sum[8:1];
        end
      end
      default: res = video;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/osd_window_cmp.sv
// One OSD window: shadow and active rectangle/mode registers plus the
// combinational hit test and window-local coordinates for the current pixel.
module osd_window_cmp
  import osd_pkg::*;
#(
  parameter int C_coord_bits = 11
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic                    wr_en,
  input  logic [2:0]              wr_field,
  input  logic [C_coord_bits-1:0] wr_data,
  input  logic                    win_en,
  input  logic [C_coord_bits-1:0] x,
  input  logic [C_coord_bits-1:0] y,
  output logic                    hit,
  output logic [C_coord_bits-1:0] lx,
  output logic [C_coord_bits-1:0] ly,
  output logic [1:0]              mode
);

  typedef logic [C_coord_bits-1:0] coord_t;

  coord_t    sh_xs_q, sh_xs_d, sh_xe_q, sh_xe_d, sh_ys_q, sh_ys_d, sh_ye_q, sh_ye_d;
  coord_t    act_xs_q, act_xs_d, act_xe_q, act_xe_d, act_ys_q, act_ys_d, act_ye_q, act_ye_d;
  osd_mode_e sh_mode_q, sh_mode_d, act_mode_q, act_mode_d;

  // The active copy takes the pre-write shadow, so a write on the load cycle waits a frame.
  always_comb begin
    sh_xs_d    = sh_xs_q;
    sh_xe_d    = sh_xe_q;
    sh_ys_d    = sh_ys_q;
    sh_ye_d    = sh_ye_q;
    sh_mode_d  = sh_mode_q;
    act_xs_d   = act_xs_q;
    act_xe_d   = act_xe_q;
    act_ys_d   = act_ys_q;
    act_ye_d   = act_ye_q;
    act_mode_d = act_mode_q;
    if (load) begin
      act_xs_d   = sh_xs_q;
      act_xe_d   = sh_xe_q;
      act_ys_d   = sh_ys_q;
      act_ye_d   = sh_ye_q;
      act_mode_d = sh_mode_q;
    end
    if (wr_en) begin
      case (wr_field)
        OSD_F_XS:   sh_xs_d   = wr_data;
        OSD_F_XE:   sh_xe_d   = wr_data;
        OSD_F_YS:   sh_ys_d   = wr_data;
        OSD_F_YE:   sh_ye_d   = wr_data;
        OSD_F_MODE: sh_mode_d = osd_mode_e'(wr_data[1:0]);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_xs_q    <= '0;
      sh_xe_q    <= '0;
      sh_ys_q    <= '0;
      sh_ye_q    <= '0;
      sh_mode_q  <= OSD_OFF;
      act_xs_q   <= '0;
      act_xe_q   <= '0;
      act_ys_q   <= '0;
      act_ye_q   <= '0;
      act_mode_q <= OSD_OFF;
    end else begin
      sh_xs_q    <= sh_xs_d;
      sh_xe_q    <= sh_xe_d;
      sh_ys_q    <= sh_ys_d;
      sh_ye_q    <= sh_ye_d;
      sh_mode_q  <= sh_mode_d;
      act_xs_q   <= act_xs_d;
      act_xe_q   <= act_xe_d;
      act_ys_q   <= act_ys_d;
      act_ye_q   <= act_ye_d;
      act_mode_q <= act_mode_d;
    end
  end

  assign hit  = win_en && (act_mode_q != OSD_OFF) &&
                (x >= act_xs_q) && (x <= act_xe_q) &&
                (y >= act_ys_q) && (y <= act_ye_q);
  assign lx   = x - act_xs_q;
  assign ly   = y - act_ys_q;
  assign mode = act_mode_q;

endmodule

// File: rtl/osd_mixer_multi.sv
// Multi-window OSD mixer: screen counters, per-window compare, priority select
// and a two-stage pipeline that mixes OSD pixels into rgb888 video.
module osd_mixer_multi
  import osd_pkg::*;
#(
  parameter int C_windows    = 2,
  parameter int C_coord_bits = 11,
  localparam int WIN_BITS    = (C_windows > 1) ? $clog2(C_windows) : 1,
  localparam int CFG_AW      = 3 + $clog2(C_windows)
) (
  input  logic                    clk_pixel,
  input  logic                    rst,
  input  logic                    clk_pixel_ena,
  input  logic [7:0]              i_r,
  input  logic [7:0]              i_g,
  input  logic [7:0]              i_b,
  input  logic                    i_hsync,
  input  logic                    i_vsync,
  input  logic                    i_blank,
  input  logic [C_windows-1:0]    i_osd_en,
  input  logic                    cfg_we,
  input  logic [CFG_AW-1:0]       cfg_addr,
  input  logic [C_coord_bits-1:0] cfg_data,
  output logic [C_coord_bits-1:0] o_osd_x,
  output logic [C_coord_bits-1:0] o_osd_y,
  output logic [WIN_BITS-1:0]     o_osd_win,
  output logic                    o_osd_active,
  input  logic [7:0]              i_osd_r,
  input  logic [7:0]              i_osd_g,
  input  logic [7:0]              i_osd_b,
  output logic [7:0]              o_r,
  output logic [7:0]              o_g,
  output logic [7:0]              o_b,
  output logic                    o_hsync,
  output logic                    o_vsync,
  output logic                    o_blank
);

  typedef logic [C_coord_bits-1:0] coord_t;

  coord_t x_q, x_d, y_q, y_d, cur_x, cur_y;
  logic   blank_prev_q, blank_prev_d, vsync_prev_q, vsync_prev_d;
  logic   load;

  logic [C_windows-1:0] hit;
  coord_t               lx [C_windows];
  coord_t               ly [C_windows];
  logic [1:0]           wmode [C_windows];
  logic [CFG_AW-1:0]    cfg_win;

  logic                sel_hit;
  logic [WIN_BITS-1:0] sel_win;
  coord_t              sel_x, sel_y;
  osd_mode_e           sel_mode;

  logic                s1_act_q, s1_act_d;
  logic [WIN_BITS-1:0] s1_win_q, s1_win_d;
  coord_t              s1_x_q, s1_x_d, s1_y_q, s1_y_d;
  osd_mode_e           s1_mode_q, s1_mode_d;
  logic [23:0]         s1_rgb_q, s1_rgb_d;
  logic [2:0]          s1_sync_q, s1_sync_d;
  logic [23:0]         s2_rgb_q, s2_rgb_d;
  logic [2:0]          s2_sync_q, s2_sync_d;

  // x_q/y_q hold the coordinate the next active pixel will carry.
  assign cur_x   = i_blank ? '0 : x_q;
  assign cur_y   = i_vsync ? '0 : y_q;
  assign load    = clk_pixel_ena && i_vsync && !vsync_prev_q;
  assign cfg_win = cfg_addr >> 3;

  always_comb begin
    x_d          = x_q;
    y_d          = y_q;
    blank_prev_d = blank_prev_q;
    vsync_prev_d = vsync_prev_q;
    if (clk_pixel_ena) begin
      blank_prev_d = i_blank;
      vsync_prev_d = i_vsync;
      if (i_blank)
        x_d = '0;
      else if (x_q != '1)
        x_d = x_q + 1'b1;
      if (i_vsync)
        y_d = '0;
      else if (i_blank && !blank_prev_q && (y_q != '1))
        y_d = y_q + 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < C_windows; gi++) begin : g_win
      osd_window_cmp #(
        .C_coord_bits(C_coord_bits)
      ) u_cmp (
        .clk      (clk_pixel),
        .rst      (rst),
        .load     (load),
        .wr_en    (cfg_we && (cfg_win == CFG_AW'(gi))),
        .wr_field (cfg_addr[2:0]),
        .wr_data  (cfg_data),
        .win_en   (i_osd_en[gi]),
        .x        (cur_x),
        .y        (cur_y),
        .hit      (hit[gi]),
        .lx       (lx[gi]),
        .ly       (ly[gi]),
        .mode     (wmode[gi])
      );
    end
  endgenerate

  // Scanning from the top index down leaves the lowest hitting window selected.
  always_comb begin
    sel_hit  = 1'b0;
    sel_win  = '0;
    sel_x    = '0;
    sel_y    = '0;
    sel_mode = OSD_OFF;
    for (int i = C_windows - 1; i >= 0; i--) begin
      if (hit[i]) begin
        sel_hit  = 1'b1;
        sel_win  = WIN_BITS'(i);
        sel_x    = lx[i];
        sel_y    = ly[i];
        sel_mode = osd_mode_e'(wmode[i]);
      end
    end
  end

  always_comb begin
    s1_act_d  = s1_act_q;
    s1_win_d  = s1_win_q;
    s1_x_d    = s1_x_q;
    s1_y_d    = s1_y_q;
    s1_mode_d = s1_mode_q;
    s1_rgb_d  = s1_rgb_q;
    s1_sync_d = s1_sync_q;
    s2_rgb_d  = s2_rgb_q;
    s2_sync_d = s2_sync_q;
    if (clk_pixel_ena) begin
      s1_act_d  = sel_hit;
      s1_win_d  = sel_win;
      s1_x_d    = sel_x;
      s1_y_d    = sel_y;
      s1_mode_d = sel_mode;
      s1_rgb_d  = {i_r, i_g, i_b};
      s1_sync_d = {i_hsync, i_vsync, i_blank};
      s2_rgb_d  = s1_sync_q[0] ? 24'h000000
                               : osd_mix(s1_mode_q, s1_rgb_q, {i_osd_r, i_osd_g, i_osd_b});
      s2_sync_d = s1_sync_q;
    end
  end

  always_ff @(posedge clk_pixel or posedge rst) begin
    if (rst) begin
      x_q          <= '0;
      y_q          <= '0;
      blank_prev_q <= 1'b0;
      vsync_prev_q <= 1'b0;
      s1_act_q     <= 1'b0;
      s1_win_q     <= '0;
      s1_x_q       <= '0;
      s1_y_q       <= '0;
      s1_mode_q    <= OSD_OFF;
      s1_rgb_q     <= '0;
      s1_sync_q    <= '0;
      s2_rgb_q     <= '0;
      s2_sync_q    <= '0;
    end else begin
      x_q          <= x_d;
      y_q          <= y_d;
      blank_prev_q <= blank_prev_d;
      vsync_prev_q <= vsync_prev_d;
      s1_act_q     <= s1_act_d;
      s1_win_q     <= s1_win_d;
      s1_x_q       <= s1_x_d;
      s1_y_q       <= s1_y_d;
      s1_mode_q    <= s1_mode_d;
      s1_rgb_q     <= s1_rgb_d;
      s1_sync_q    <= s1_sync_d;
      s2_rgb_q     <= s2_rgb_d;
      s2_sync_q    <= s2_sync_d;
    end
  end

  assign o_osd_active = s1_act_q;
  assign o_osd_win    = s1_win_q;
  assign o_osd_x      = s1_x_q;
  assign o_osd_y      = s1_y_q;
  assign {o_r, o_g, o_b} = s2_rgb_q;
  assign {o_hsync, o_vsync, o_blank} = s2_sync_q;

endmodule

// File: tb/tb_osd_mixer_multi.sv
// Directed bench for osd_mixer_multi: hand-computed pixels, expected rgb/syncs
// tracked two enabled cycles behind the driven pixel.
module tb_osd_mixer_multi;

  logic        clk_pixel = 1'b0;
  logic        rst;
  logic        clk_pixel_ena;
  logic [7:0]  i_r, i_g, i_b;
  logic        i_hsync, i_vsync, i_blank;
  logic [1:0]  i_osd_en;
  logic        cfg_we;
  logic [3:0]  cfg_addr;
  logic [10:0] cfg_data;
  logic [10:0] o_osd_x, o_osd_y;
  logic [0:0]  o_osd_win;
  logic        o_osd_active;
  logic [7:0]  i_osd_r, i_osd_g, i_osd_b;
  logic [7:0]  o_r, o_g, o_b;
  logic        o_hsync, o_vsync, o_blank;

  osd_mixer_multi #(.C_windows(2), .C_coord_bits(11)) dut (
    .clk_pixel(clk_pixel), .rst(rst), .clk_pixel_ena(clk_pixel_ena),
    .i_r(i_r), .i_g(i_g), .i_b(i_b),
    .i_hsync(i_hsync), .i_vsync(i_vsync), .i_blank(i_blank),
    .i_osd_en(i_osd_en), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .o_osd_x(o_osd_x), .o_osd_y(o_osd_y), .o_osd_win(o_osd_win), .o_osd_active(o_osd_active),
    .i_osd_r(i_osd_r), .i_osd_g(i_osd_g), .i_osd_b(i_osd_b),
    .o_r(o_r), .o_g(o_g), .o_b(o_b),
    .o_hsync(o_hsync), .o_vsync(o_vsync), .o_blank(o_blank)
  );

  always #5 clk_pixel = ~clk_pixel;

  localparam logic [23:0] V  = 24'h203040;
  localparam logic [23:0] VV = 24'h4061FE;

  int          total = 0;
  int          bad = 0;
  logic [23:0] pend_rgb, last_rgb;
  logic [2:0]  pend_sync;
  logic        pend_vld = 1'b0;
  logic        last_vld = 1'b0;
  string       pend_tag = "";

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock; on enabled cycles the output must show the previous enabled pixel.
  task automatic tick(input string tag, input logic [23:0] exp_rgb);
    logic en_now;
    en_now = clk_pixel_ena;
    @(posedge clk_pixel);
    #1;
    if (en_now) begin
      if (pend_vld) begin
        chk_eq({pend_tag, "_rgb"}, {8'h0, o_r, o_g, o_b}, {8'h0, pend_rgb});
        chk_eq({pend_tag, "_sync"}, {29'h0, o_hsync, o_vsync, o_blank}, {29'h0, pend_sync});
      end
      last_rgb  = pend_rgb;
      last_vld  = pend_vld;
      pend_rgb  = exp_rgb;
      pend_sync = {i_hsync, i_vsync, i_blank};
      pend_tag  = tag;
      pend_vld  = 1'b1;
    end else if (last_vld) begin
      chk_eq({tag, "_hold"}, {8'h0, o_r, o_g, o_b}, {8'h0, last_rgb});
    end
  endtask

  task automatic pix(input string tag, input logic [23:0] v, input logic [23:0] exp);
    i_blank = 1'b0; i_vsync = 1'b0; i_hsync = 1'b0;
    {i_r, i_g, i_b} = v;
    tick(tag, exp);
  endtask

  task automatic run(input string tag, input int n, input logic [23:0] v, input logic [23:0] exp);
    repeat (n) pix(tag, v, exp);
  endtask

  task automatic blk(input int n);
    repeat (n) begin
      i_blank = 1'b1; i_vsync = 1'b0; i_hsync = 1'b1;
      {i_r, i_g, i_b} = 24'hABCDEF;
      tick("blank", 24'h0);
    end
  endtask

  task automatic cfg(input logic w, input logic [2:0] f, input logic [10:0] d);
    cfg_we = 1'b1; cfg_addr = {w, f}; cfg_data = d;
    blk(1);
    cfg_we = 1'b0;
  endtask

  task automatic win_cfg(input logic w, input logic [10:0] xs, input logic [10:0] xe,
                         input logic [10:0] ys, input logic [10:0] ye, input logic [1:0] m);
    cfg(w, 3'd0, xs); cfg(w, 3'd1, xe); cfg(w, 3'd2, ys); cfg(w, 3'd3, ye);
    cfg(w, 3'd4, {9'h0, m});
  endtask

  task automatic new_frame(input logic wr, input logic [3:0] addr, input logic [10:0] data);
    blk(1);
    i_vsync = 1'b1; i_blank = 1'b1; i_hsync = 1'b0;
    cfg_we = wr; cfg_addr = addr; cfg_data = data;
    tick("vsync", 24'h0);
    cfg_we = 1'b0;
    tick("vsync", 24'h0);
    blk(2);
  endtask

  task automatic skip_lines(input int n);
    repeat (n) begin
      pix("skip", 24'h0A0B0C, 24'h0A0B0C);
      blk(1);
    end
  endtask

  task automatic osd_chk(input string tag, input logic act, input logic win,
                         input logic [10:0] x, input logic [10:0] y);
    chk_eq({tag, "_act"}, {31'h0, o_osd_active}, {31'h0, act});
    chk_eq({tag, "_win"}, {31'h0, o_osd_win}, {31'h0, win});
    chk_eq({tag, "_ox"}, {21'h0, o_osd_x}, {21'h0, x});
    chk_eq({tag, "_oy"}, {21'h0, o_osd_y}, {21'h0, y});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [23:0] v6;
    rst = 1'b1; clk_pixel_ena = 1'b1;
    {i_r, i_g, i_b} = 24'h0; i_hsync = 1'b0; i_vsync = 1'b0; i_blank = 1'b1;
    i_osd_en = 2'b11; cfg_we = 1'b0; cfg_addr = 4'h0; cfg_data = 11'h0;
    {i_osd_r, i_osd_g, i_osd_b} = 24'h0;
    repeat (3) @(posedge clk_pixel);
    #1;
    chk_eq("rst_rgb", {8'h0, o_r, o_g, o_b}, 32'h0);
    chk_eq("rst_sync", {29'h0, o_hsync, o_vsync, o_blank}, 32'h0);
    osd_chk("rst_osd", 1'b0, 1'b0, 11'd0, 11'd0);

    // T1: pass-through, then reset asserted mid-line
    rst = 1'b0;
    blk(2);
    pix("t1_a", 24'h112233, 24'h112233);
    pix("t1_b", 24'h445566, 24'h445566);
    pix("t1_c", 24'h778899, 24'h778899);
    pix("t1_d", 24'hAABBCC, 24'hAABBCC);
    #2 rst = 1'b1;
    #1;
    chk_eq("t1_rst_rgb", {8'h0, o_r, o_g, o_b}, 32'h0);
    chk_eq("t1_rst_sync", {29'h0, o_hsync, o_vsync, o_blank}, 32'h0);
    osd_chk("t1_rst_osd", 1'b0, 1'b0, 11'd0, 11'd0);
    repeat (2) @(posedge clk_pixel);
    #1;
    pend_vld = 1'b0; last_vld = 1'b0;
    rst = 1'b0;
    blk(1);
    for (int i = 0; i < 6; i++)
      pix("t1_pass", {8'(i * 17), 8'(i * 3 + 1), 8'(255 - i)}, {8'(i * 17), 8'(i * 3 + 1), 8'(255 - i)});
    blk(1);

    // T2: opaque window 0 at (96..191, 96..127)
    win_cfg(1'b0, 11'd96, 11'd191, 11'd96, 11'd127, 2'd1);
    {i_osd_r, i_osd_g, i_osd_b} = 24'hFF0000;
    new_frame(1'b0, 4'h0, 11'h0);
    skip_lines(96);
    run("t2_pre", 95, V, V);
    pix("t2_x95", V, V);          osd_chk("t2_x95", 1'b0, 1'b0, 11'd0, 11'd0);
    pix("t2_x96", V, 24'hFF0000); osd_chk("t2_x96", 1'b1, 1'b0, 11'd0, 11'd0);
    pix("t2_x97", V, 24'hFF0000); osd_chk("t2_x97", 1'b1, 1'b0, 11'd1, 11'd0);
    run("t2_in", 93, V, 24'hFF0000);
    pix("t2_x191", V, 24'hFF0000); osd_chk("t2_x191", 1'b1, 1'b0, 11'd95, 11'd0);
    pix("t2_x192", V, V);          osd_chk("t2_x192", 1'b0, 1'b0, 11'd0, 11'd0);
    blk(1);

    // T3: mid-frame rewrite stays shadowed; write on the vsync edge waits a frame
    cfg(1'b0, 3'd0, 11'd200);
    cfg(1'b0, 3'd1, 11'd250);
    run("t3_y97", 96, V, V);
    pix("t3_y97_x96", V, 24'hFF0000); osd_chk("t3_y97_x96", 1'b1, 1'b0, 11'd0, 11'd1);
    blk(1);
    new_frame(1'b1, 4'h0, 11'd100);
    skip_lines(96);
    run("t3_f2", 100, V, V);
    pix("t3_f2_x100", V, V);          osd_chk("t3_f2_x100", 1'b0, 1'b0, 11'd0, 11'd0);
    run("t3_f2", 98, V, V);
    pix("t3_f2_x199", V, V);
    pix("t3_f2_x200", V, 24'hFF0000); osd_chk("t3_f2_x200", 1'b1, 1'b0, 11'd0, 11'd0);
    blk(1);
    new_frame(1'b0, 4'h0, 11'h0);
    skip_lines(96);
    run("t3_f3", 99, V, V);
    pix("t3_f3_x99", V, V);
    pix("t3_f3_x100", V, 24'hFF0000); osd_chk("t3_f3_x100", 1'b1, 1'b0, 11'd0, 11'd0);
    blk(1);

    // T4: win0 blend over win1 key
    win_cfg(1'b0, 11'd10, 11'd19, 11'd0, 11'd1, 2'd3);
    win_cfg(1'b1, 11'd10, 11'd29, 11'd0, 11'd1, 2'd2);
    {i_osd_r, i_osd_g, i_osd_b} = 24'hC0C103;
    new_frame(1'b0, 4'h0, 11'h0);
    run("t4_l0_out", 10, VV, VV);
    pix("t4_l0_x10", VV, 24'h809180); osd_chk("t4_l0_x10", 1'b1, 1'b0, 11'd0, 11'd0);
    run("t4_l0_blend", 9, VV, 24'h809180);
    pix("t4_l0_x20", VV, 24'hC0C103); osd_chk("t4_l0_x20", 1'b1, 1'b1, 11'd10, 11'd0);
    run("t4_l0_key", 9, VV, 24'hC0C103);
    pix("t4_l0_x30", VV, VV);         osd_chk("t4_l0_x30", 1'b0, 1'b0, 11'd0, 11'd0);
    blk(1);
    {i_osd_r, i_osd_g, i_osd_b} = 24'h000000;
    run("t4_l1_out", 10, VV, VV);
    pix("t4_l1_x10", VV, 24'h20307F); osd_chk("t4_l1_x10", 1'b1, 1'b0, 11'd0, 11'd1);
    run("t4_l1_blend", 9, VV, 24'h20307F);
    pix("t4_l1_x20", VV, VV);         osd_chk("t4_l1_x20", 1'b1, 1'b1, 11'd10, 11'd1);
    blk(1);

    // T5: single-pixel window, inverted window, enable mask
    win_cfg(1'b0, 11'd0, 11'd0, 11'd0, 11'd1, 2'd1);
    win_cfg(1'b1, 11'd3, 11'd2, 11'd0, 11'd1, 2'd1);
    {i_osd_r, i_osd_g, i_osd_b} = 24'hFF00FF;
    new_frame(1'b0, 4'h0, 11'h0);
    pix("t5_x0", V, 24'hFF00FF); osd_chk("t5_x0", 1'b1, 1'b0, 11'd0, 11'd0);
    pix("t5_x1", V, V);          osd_chk("t5_x1", 1'b0, 1'b0, 11'd0, 11'd0);
    pix("t5_x2", V, V);          osd_chk("t5_x2", 1'b0, 1'b0, 11'd0, 11'd0);
    pix("t5_x3", V, V);          osd_chk("t5_x3", 1'b0, 1'b0, 11'd0, 11'd0);
    blk(1);
    cfg(1'b1, 3'd0, 11'd0);
    pix("t5_l1_x0", V, 24'hFF00FF); osd_chk("t5_l1_x0", 1'b1, 1'b0, 11'd0, 11'd1);
    blk(1);
    new_frame(1'b0, 4'h0, 11'h0);
    pix("t5_ovl", V, 24'hFF00FF); osd_chk("t5_ovl", 1'b1, 1'b0, 11'd0, 11'd0);
    blk(1);
    i_osd_en = 2'b10;
    pix("t5_en_x0", V, 24'hFF00FF); osd_chk("t5_en_x0", 1'b1, 1'b1, 11'd0, 11'd1);
    pix("t5_en_x1", V, 24'hFF00FF); osd_chk("t5_en_x1", 1'b1, 1'b1, 11'd1, 11'd1);
    pix("t5_en_x2", V, 24'hFF00FF);
    pix("t5_en_x3", V, V);          osd_chk("t5_en_x3", 1'b0, 1'b0, 11'd0, 11'd0);
    blk(1);
    i_osd_en = 2'b11;

    // T6: pixel enable toggling, garbage driven while disabled
    {i_osd_r, i_osd_g, i_osd_b} = 24'h13579B;
    new_frame(1'b0, 4'h0, 11'h0);
    for (int i = 0; i < 6; i++) begin
      v6 = {8'(8'h10 + i), 8'(8'h80 - i), 8'(8'hC0 ^ i)};
      clk_pixel_ena = 1'b1;
      pix("t6_on", v6, (i < 3) ? 24'h13579B : v6);
      clk_pixel_ena = 1'b0;
      pix("t6_off", 24'hDEAD00 ^ 24'(i), 24'h0);
    end
    for (int i = 0; i < 3; i++) begin
      clk_pixel_ena = 1'b1;
      blk(1);
      clk_pixel_ena = 1'b0;
      blk(1);
    end
    clk_pixel_ena = 1'b1;
    blk(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
